// File: rtl/oled_pkg.sv
// Shared types and the round-robin search helper for the oled_controller write-port arbiter.
package oled_pkg;

  localparam int unsigned OLED_DATA_W    = 8;
  localparam int unsigned OLED_MAX_REQ   = 8;
  localparam int unsigned OLED_MAX_IDX_W = 3;

  typedef enum logic {
    ARB   = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                      found;
    logic [OLED_MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid at or after ptr, wrapping modulo n (n <= OLED_MAX_REQ).
  function automatic rr_pick_t rr_pick(input logic [OLED_MAX_REQ-1:0] valid,
                                       input logic [OLED_MAX_IDX_W-1:0] ptr,
                                       input int unsigned n);
    rr_pick_t    r;
    int unsigned cand;
    r = '0;
    for (int unsigned k = 0; k < OLED_MAX_REQ; k++) begin
      cand = (32'(ptr) + k) % n;
      if (k < n && !r.found && valid[OLED_MAX_IDX_W'(cand)]) begin
        r.found = 1'b1;
        r.idx   = OLED_MAX_IDX_W'(cand);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/oled_rr_picker.sv
// Combinational rotate/priority-encode: picks the next requester at or after ptr.
module oled_rr_picker
  import oled_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] ptr,
  output logic             found_c,
  output logic [IDX_W-1:0] idx_c
);

  rr_pick_t pick;

  assign pick    = rr_pick(OLED_MAX_REQ'(valid), OLED_MAX_IDX_W'(ptr), N_REQ);
  assign found_c = pick.found;
  assign idx_c   = IDX_W'(pick.idx);

endmodule

// File: rtl/oled_wr_arbiter.sv
// Round-robin, packet-locking arbiter for the oled_controller byte-write port.
// Define OLED_ARB_TIMEOUT_EN to revoke a grant whose holder stalls for IDLE_TIMEOUT cycles.
module oled_wr_arbiter
  import oled_pkg::*;
#(
  parameter  int unsigned N_REQ        = 4,
  parameter  int unsigned DATA_W       = OLED_DATA_W,
  parameter  int unsigned MAX_BURST    = 16,
  parameter  int unsigned IDLE_TIMEOUT = 32,
  localparam int unsigned IDX_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_we,
  input  logic                    buffer_full,
  output logic                    grant_valid,
  output logic [IDX_W-1:0]        grant_id
);

  localparam int unsigned BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  if (N_REQ < 1 || N_REQ > OLED_MAX_REQ || MAX_BURST < 1 || IDLE_TIMEOUT < 1) begin : g_bad_cfg
    $error("oled_wr_arbiter: unsupported parameter set");
  end

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [BURST_W-1:0] burst_cnt;

  logic              pick_found_c;
  logic [IDX_W-1:0]  pick_idx_c;
  logic              sel_valid_c;
  logic              sel_last_c;
  logic [DATA_W-1:0] sel_data_c;
  logic              xfer_c;
  logic              release_c;
  logic [IDX_W-1:0]  next_ptr_c;

  oled_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .valid   (req_valid),
    .ptr     (rr_ptr),
    .found_c (pick_found_c),
    .idx_c   (pick_idx_c)
  );

  // Holder's lane and the accept/release decisions for this cycle.
  always_comb begin
    sel_valid_c = req_valid[grant_id];
    sel_last_c  = req_last[grant_id];
    sel_data_c  = req_data[32'(grant_id)*DATA_W +: DATA_W];
    xfer_c      = !reset && (state == GRANT) && sel_valid_c && !buffer_full;
    release_c   = xfer_c && (sel_last_c || (burst_cnt == BURST_W'(MAX_BURST - 1)));
    next_ptr_c  = (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
  end

  // Only the holder can see ready, and only on the cycle its byte is taken.
  always_comb begin
    req_ready = '0;
    if (xfer_c) begin
      req_ready[grant_id] = 1'b1;
    end
  end

`ifdef OLED_ARB_TIMEOUT_EN
  localparam int unsigned STALL_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

  logic [STALL_W-1:0] stall_cnt;
  logic               revoke_c;

  // Only a holder that has gone quiet counts; buffer_full stalls do not.
  assign revoke_c = (state == GRANT) && !sel_valid_c &&
                    (stall_cnt == STALL_W'(IDLE_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (state != GRANT || xfer_c || revoke_c) begin
      stall_cnt <= '0;
    end else if (!sel_valid_c) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end
`else
  logic revoke_c;
  assign revoke_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARB;
      rr_ptr      <= '0;
      burst_cnt   <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      out_we      <= 1'b0;
      out_data    <= '0;
    end else begin
      out_we <= 1'b0;
      case (state)
        ARB: begin
          if (pick_found_c) begin
            grant_id    <= pick_idx_c;
            grant_valid <= 1'b1;
            burst_cnt   <= '0;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (xfer_c) begin
            out_data  <= sel_data_c;
            out_we    <= 1'b1;
            burst_cnt <= burst_cnt + BURST_W'(1);
          end
          // grant_id is left alone on release so the final write still carries its owner.
          if (release_c || revoke_c) begin
            grant_valid <= 1'b0;
            rr_ptr      <= next_ptr_c;
            state       <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
